// File: rtl/cache_miss_ctrl.sv
// Miss-handling sequencer for a write-back data cache: stalls the pipeline,
// writes back a dirty victim, refills the missing block and signals the fill.
module cache_miss_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  hit,
    input  logic                  victim_dirty,
    input  logic [ADDR_WIDTH-1:0] victim_addr,
    input  logic                  mem_ack,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  fill_en,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic [CNT_WIDTH-1:0]  wb_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_UPDATE    = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] r_miss_addr;
    logic                  r_fill_en;
    logic [CNT_WIDTH-1:0]  r_miss_count;
    logic [CNT_WIDTH-1:0]  r_wb_count;

    logic                  w_miss;
    logic [ADDR_WIDTH-1:0] w_miss_addr;
    logic                  w_unused;

    assign w_miss      = cpu_req_valid & ~hit;
    assign w_miss_addr = {cpu_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    // The store/load distinction and the word offset only matter to the cache itself.
    assign w_unused = &{1'b0, cpu_req_we, cpu_addr[OFFSET_BITS-1:0]};

    // Combinational so the missing instruction is frozen in the very cycle it misses.
    assign stall = (r_state != ST_IDLE) | w_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_miss_addr  <= '0;
            r_fill_en    <= 1'b0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            // NOTE: non-blocking throughout; the default below is overridden later in the same cycle.
            r_fill_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_mem_req <= 1'b0;
                    if (w_miss) begin
                        r_miss_addr <= w_miss_addr;
                        r_mem_req   <= 1'b1;
                        if (r_miss_count != '1)
                            r_miss_count <= r_miss_count + CNT_WIDTH'(1);
                        if (victim_dirty) begin
                            r_state    <= ST_WRITEBACK;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= victim_addr;
                            if (r_wb_count != '1)
                                r_wb_count <= r_wb_count + CNT_WIDTH'(1);
                        end else begin
                            r_state    <= ST_REFILL;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_miss_addr;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack) begin
                        r_state    <= ST_REFILL;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_miss_addr;
                    end
                end
                ST_REFILL: begin
                    if (mem_ack) begin
                        r_state   <= ST_UPDATE;
                        r_mem_req <= 1'b0;
                        r_fill_en <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign fill_en    = r_fill_en;
    assign miss_count = r_miss_count;
    assign wb_count   = r_wb_count;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: reset abort, clean/dirty misses,
// address latching, hit traffic and counter saturation on a 4-bit instance.
module tb_cache_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_valid;
    logic        cpu_req_we;
    logic [31:0] cpu_addr;
    logic        hit;
    logic        victim_dirty;
    logic [31:0] victim_addr;
    logic        mem_ack;

    logic        stall, mem_req, mem_we, fill_en;
    logic [31:0] mem_addr;
    logic [15:0] miss_count, wb_count;

    logic        s_stall, s_mem_req, s_mem_we, s_fill_en;
    logic [31:0] s_mem_addr;
    logic [3:0]  s_miss_count, s_wb_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_miss_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
        .cpu_addr(cpu_addr), .hit(hit), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
        .mem_ack(mem_ack), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .fill_en(fill_en), .miss_count(miss_count), .wb_count(wb_count)
    );

    cache_miss_ctrl #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
        .cpu_addr(cpu_addr), .hit(hit), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
        .mem_ack(mem_ack), .stall(s_stall), .mem_req(s_mem_req), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .fill_en(s_fill_en), .miss_count(s_miss_count), .wb_count(s_wb_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full miss: wb_wait/rf_wait = cycle (1-based) in which mem_ack is pulsed.
    task automatic do_miss(input logic [31:0] addr, input logic dirty, input logic [31:0] vaddr,
                           input int wb_wait, input int rf_wait, input logic [31:0] exp_rf_addr,
                           input int exp_stall);
        int n;
        cpu_req_valid = 1'b1;
        cpu_req_we    = dirty;
        hit           = 1'b0;
        cpu_addr      = addr;
        victim_dirty  = dirty;
        victim_addr   = vaddr;
        #1;
        check("miss_cycle_stall", stall, 1'b1);
        check("miss_cycle_req", mem_req, 1'b0);
        n = 1;
        tick();
        cpu_addr     = 32'hFFFF_FFF0;
        victim_addr  = 32'hDEAD_0000;
        victim_dirty = ~dirty;
        if (dirty) begin
            for (int i = 1; i <= wb_wait; i++) begin
                check("wb_req", mem_req, 1'b1);
                check("wb_we", mem_we, 1'b1);
                check("wb_addr", mem_addr, vaddr);
                if (stall) n++;
                if (i == wb_wait) mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
            end
        end
        for (int i = 1; i <= rf_wait; i++) begin
            check("rf_req", mem_req, 1'b1);
            check("rf_we", mem_we, 1'b0);
            check("rf_addr", mem_addr, exp_rf_addr);
            check("rf_fill", fill_en, 1'b0);
            if (stall) n++;
            if (i == rf_wait) mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        hit = 1'b1;
        #1;
        check("upd_fill", fill_en, 1'b1);
        check("upd_req", mem_req, 1'b0);
        if (stall) n++;
        tick();
        check("idle_stall", stall, 1'b0);
        check("idle_fill", fill_en, 1'b0);
        check("idle_req", mem_req, 1'b0);
        check("stall_cycles", n, exp_stall);
        cpu_req_valid = 1'b0;
    endtask

    initial begin
        logic bad;
        rst_n = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_we = 1'b0;
        cpu_addr = '0;
        hit = 1'b0;
        victim_dirty = 1'b0;
        victim_addr = '0;
        mem_ack = 1'b0;
        #12;
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_stall", stall, 1'b0);
        rst_n = 1'b1;
        tick();

        // Async reset in the middle of a refill, then a stray ack.
        cpu_req_valid = 1'b1;
        cpu_addr = 32'h0000_1234;
        tick();
        cpu_req_valid = 1'b0;
        check("pre_rst_req", mem_req, 1'b1);
        check("pre_rst_miss", miss_count, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", mem_req, 1'b0);
        check("async_rst_we", mem_we, 1'b0);
        check("async_rst_addr", mem_addr, 32'h0);
        check("async_rst_miss", miss_count, 32'd0);
        check("async_rst_stall", stall, 1'b0);
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_ack_req", mem_req, 1'b0);
        check("stray_ack_fill", fill_en, 1'b0);
        tick();
        check("stray_ack_fill2", fill_en, 1'b0);
        check("stray_ack_stall", stall, 1'b0);

        // Clean load miss, ack on 5th refill cycle -> 7 stall cycles.
        do_miss(32'h0000_1234, 1'b0, 32'h0, 0, 5, 32'h0000_1230, 7);
        check("t2_miss_cnt", miss_count, 32'd1);
        check("t2_wb_cnt", wb_count, 32'd0);

        // Dirty store miss: write-back to victim, then refill.
        do_miss(32'h0000_2008, 1'b1, 32'h0000_4000, 3, 2, 32'h0000_2000, 7);
        check("t3_miss_cnt", miss_count, 32'd2);
        check("t3_wb_cnt", wb_count, 32'd1);

        // Zero-wait clean miss with cpu_addr changing during refill -> 3 stall cycles.
        do_miss(32'h0000_1234, 1'b0, 32'h0, 0, 1, 32'h0000_1230, 3);
        check("t4_miss_cnt", miss_count, 32'd3);

        // Zero-wait dirty miss -> 4 stall cycles.
        do_miss(32'h0000_3000, 1'b1, 32'h0000_5000, 1, 1, 32'h0000_3000, 4);
        check("dz_miss_cnt", miss_count, 32'd4);
        check("dz_wb_cnt", wb_count, 32'd2);

        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_req", mem_req, 1'b0);
        check("idle_ack_fill", fill_en, 1'b0);

        // Hit-only traffic.
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cpu_req_valid = 1'b1;
            hit = 1'b1;
            cpu_addr = 32'(i * 20);
            #1;
            bad = bad | stall | mem_req;
            tick();
        end
        cpu_req_valid = 1'b0;
        check("hits_no_stall", bad, 1'b0);
        check("hits_miss_cnt", miss_count, 32'd4);

        // Drive the 4-bit instance past saturation: 4 + 13 = 17 misses.
        for (int i = 1; i <= 13; i++)
            do_miss(32'h100 * i, 1'b0, 32'h0, 0, 1, 32'h100 * i, 3);
        check("sat_wide_cnt", miss_count, 32'd17);
        check("sat_narrow_cnt", s_miss_count, 32'hF);
        check("sat_narrow_wb", s_wb_count, 32'd2);
        do_miss(32'h0000_8004, 1'b0, 32'h0, 0, 2, 32'h0000_8000, 4);
        check("sat_narrow_held", s_miss_count, 32'hF);
        check("sat_wide_cnt2", miss_count, 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
